sreg_pipeline_monitor: RTL and testbench

Synthesizable checker that sits on the far end of `sregPipeline`: it snoops the pipeline's input word, enable and output word, keeps an independent shadow delay line of the same depth, and flags every cycle where the pipeline output differs from the prediction. It is instantiated beside the pipeline in benches and FPGA bring-up builds, so a self-checking verdict (sticky error, counts, first-failure capture) replaces manual waveform inspection.

---
 rtl/sreg_pipeline_monitor.sv | 150 +++++++++++++++
 tb/tb_sreg_pipeline_monitor.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/sreg_pipeline_monitor.sv
// Shadow-delay-line checker for sregPipeline: predicts the pipeline output and flags divergence.
// Define SREG_PIPELINE_MONITOR_CAPTURE_EN to build the first-failure capture registers.
module sreg_pipeline_monitor #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic             en,
    input  logic [WIDTH-1:0] c,
    output logic [1:0]       state,
    output logic             mismatch,
    output logic             error,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] chk_count,
    output logic [WIDTH-1:0] first_exp,
    output logic [WIDTH-1:0] first_got
);

    localparam int FILL_W = $clog2(DEPTH + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(DEPTH);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [WIDTH-1:0] sh_q [DEPTH];
    logic [WIDTH-1:0] sh_d [DEPTH];
    logic             mismatch_q, mismatch_d;
    logic             error_q, error_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic [CNT_W-1:0] chk_count_q, chk_count_d;
    logic [WIDTH-1:0] pred;
    logic             diff;

    assign pred = sh_q[DEPTH-1];
    // Case inequality so an X/Z on c is reported rather than silently passing.
    assign diff = (c !== pred);

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            sh_d[k] = sh_q[k];
        end
        if (en) begin
            sh_d[0] = a;
            for (int k = 1; k < DEPTH; k++) begin
                sh_d[k] = sh_q[k-1];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        fill_d      = fill_q;
        mismatch_d  = 1'b0;
        error_d     = error_q;
        err_count_d = err_count_q;
        chk_count_d = chk_count_q;
        case (state_q)
            ST_IDLE, ST_FILL: begin
                if (en) begin
                    fill_d  = fill_q + 1'b1;
                    state_d = (fill_d == FILL_MAX) ? ST_CHECK : ST_FILL;
                end
            end
            ST_CHECK: begin
                if (chk_count_q != CNT_MAX) begin
                    chk_count_d = chk_count_q + 1'b1;
                end
                if (diff) begin
                    mismatch_d = 1'b1;
                    error_d    = 1'b1;
                    if (err_count_q != CNT_MAX) begin
                        err_count_d = err_count_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            fill_q      <= '0;
            mismatch_q  <= 1'b0;
            error_q     <= 1'b0;
            err_count_q <= '0;
            chk_count_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                sh_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            fill_q      <= fill_d;
            mismatch_q  <= mismatch_d;
            error_q     <= error_d;
            err_count_q <= err_count_d;
            chk_count_q <= chk_count_d;
            for (int k = 0; k < DEPTH; k++) begin
                sh_q[k] <= sh_d[k];
            end
        end
    end

`ifdef SREG_PIPELINE_MONITOR_CAPTURE_EN
    logic [WIDTH-1:0] first_exp_q, first_exp_d;
    logic [WIDTH-1:0] first_got_q, first_got_d;

    // Only the very first mismatch is latched; later ones leave the capture alone.
    always_comb begin
        first_exp_d = first_exp_q;
        first_got_d = first_got_q;
        if (state_q == ST_CHECK && diff && !error_q) begin
            first_exp_d = pred;
            first_got_d = c;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            first_exp_q <= '0;
            first_got_q <= '0;
        end else begin
            first_exp_q <= first_exp_d;
            first_got_q <= first_got_d;
        end
    end

    assign first_exp = first_exp_q;
    assign first_got = first_got_q;
`else
    assign first_exp = '0;
    assign first_got = '0;
`endif

    assign state     = state_q;
    assign mismatch  = mismatch_q;
    assign error     = error_q;
    assign err_count = err_count_q;
    assign chk_count = chk_count_q;

endmodule

// File: tb/tb_sreg_pipeline_monitor.sv
// Directed bench for sreg_pipeline_monitor: a behavioural DEPTH=4 pipeline drives c,
// with forced corruptions of c to provoke mismatches; expected values are hand-computed.
module tb_sreg_pipeline_monitor;

    logic        clock;
    logic        reset;
    logic [8:0]  a;
    logic        en;
    logic [8:0]  c;
    logic [1:0]  state;
    logic        mismatch;
    logic        error;
    logic [15:0] err_count;
    logic [15:0] chk_count;
    logic [8:0]  first_exp;
    logic [8:0]  first_got;

    logic [1:0]  sat_state;
    logic        sat_mismatch;
    logic        sat_error;
    logic [3:0]  sat_err_count;
    logic [3:0]  sat_chk_count;
    logic [8:0]  sat_first_exp;
    logic [8:0]  sat_first_got;

    logic [8:0]  pipe [4];
    logic        force_en;
    logic [8:0]  force_val;

    int compared;
    int mismatched;

    sreg_pipeline_monitor #(.WIDTH(9), .DEPTH(4), .CNT_W(16)) u_dut (
        .clock(clock), .reset(reset), .a(a), .en(en), .c(c),
        .state(state), .mismatch(mismatch), .error(error),
        .err_count(err_count), .chk_count(chk_count),
        .first_exp(first_exp), .first_got(first_got)
    );

    sreg_pipeline_monitor #(.WIDTH(9), .DEPTH(4), .CNT_W(4)) u_sat (
        .clock(clock), .reset(reset), .a(a), .en(en), .c(c),
        .state(sat_state), .mismatch(sat_mismatch), .error(sat_error),
        .err_count(sat_err_count), .chk_count(sat_chk_count),
        .first_exp(sat_first_exp), .first_got(sat_first_got)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Stand-in for the monitored pipeline: four enabled shifts from a to c.
    always @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < 4; k++) pipe[k] <= '0;
        end else if (en) begin
            pipe[0] <= a;
            for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
        end
    end

    assign c = force_en ? force_val : pipe[3];

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic e, input logic [8:0] av);
        reset = rst;
        en    = e;
        a     = av;
        @(posedge clock);
        #1;
    endtask

    task automatic checkClear(input string tag);
        checkOutput({tag, "_state"}, 32'(state), 0);
        checkOutput({tag, "_mismatch"}, 32'(mismatch), 0);
        checkOutput({tag, "_error"}, 32'(error), 0);
        checkOutput({tag, "_err_count"}, 32'(err_count), 0);
        checkOutput({tag, "_chk_count"}, 32'(chk_count), 0);
        checkOutput({tag, "_first_exp"}, 32'(first_exp), 0);
        checkOutput({tag, "_first_got"}, 32'(first_got), 0);
    endtask

    int val;
    logic capture_on;

    initial begin
        compared   = 0;
        mismatched = 0;
        force_en   = 1'b0;
        force_val  = '0;
`ifdef SREG_PIPELINE_MONITOR_CAPTURE_EN
        capture_on = 1'b1;
`else
        capture_on = 1'b0;
`endif
        $display("[TB] starting sreg_pipeline_monitor bench");

        // Reset and fill with a = 1,2,3,...
        applyStimulus(1'b1, 1'b0, 9'd0);
        applyStimulus(1'b1, 1'b0, 9'd0);
        checkClear("reset");

        val = 1;
        applyStimulus(1'b0, 1'b1, 9'(val)); val++;
        checkOutput("fill_state_1", 32'(state), 1);
        applyStimulus(1'b0, 1'b1, 9'(val)); val++;
        applyStimulus(1'b0, 1'b1, 9'(val)); val++;
        checkOutput("fill_state_3", 32'(state), 1);
        checkOutput("fill_chk_3", 32'(chk_count), 0);
        applyStimulus(1'b0, 1'b1, 9'(val)); val++;
        checkOutput("check_state_4", 32'(state), 2);
        checkOutput("check_chk_4", 32'(chk_count), 0);

        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 1'b1, 9'(val)); val++;
            checkOutput("clean_mismatch", 32'(mismatch), 0);
        end
        checkOutput("clean_chk_20", 32'(chk_count), 20);
        checkOutput("clean_err_0", 32'(err_count), 0);
        checkOutput("clean_error_0", 32'(error), 0);
        checkOutput("sat_chk_15", 32'(sat_chk_count), 15);
        checkOutput("sat_err_0", 32'(sat_err_count), 0);

        // Edge 25: pipeline would show 21, force 1FF.
        force_en = 1'b1; force_val = 9'h1FF;
        applyStimulus(1'b0, 1'b1, 9'(val)); val++;
        force_en = 1'b0;
        checkOutput("inj1_mismatch", 32'(mismatch), 1);
        checkOutput("inj1_error", 32'(error), 1);
        checkOutput("inj1_err_count", 32'(err_count), 1);
        checkOutput("inj1_chk_count", 32'(chk_count), 21);
        checkOutput("inj1_first_got", 32'(first_got), capture_on ? 32'h1FF : 32'h0);
        checkOutput("inj1_first_exp", 32'(first_exp), capture_on ? 32'd21 : 32'h0);

        applyStimulus(1'b0, 1'b1, 9'(val)); val++;
        checkOutput("post1_mismatch", 32'(mismatch), 0);
        checkOutput("post1_error", 32'(error), 1);
        checkOutput("post1_err_count", 32'(err_count), 1);

        // Edge 27: expected 23, force 0AA; capture must not move.
        force_en = 1'b1; force_val = 9'h0AA;
        applyStimulus(1'b0, 1'b1, 9'(val)); val++;
        checkOutput("inj2_mismatch", 32'(mismatch), 1);
        checkOutput("inj2_err_count", 32'(err_count), 2);
        checkOutput("inj2_first_got", 32'(first_got), capture_on ? 32'h1FF : 32'h0);
        checkOutput("inj2_first_exp", 32'(first_exp), capture_on ? 32'd21 : 32'h0);

        // Edge 28: expected 24, force 0 (back-to-back mismatch).
        force_val = 9'h000;
        applyStimulus(1'b0, 1'b1, 9'(val)); val++;
        force_en = 1'b0;
        checkOutput("inj3_mismatch", 32'(mismatch), 1);
        checkOutput("inj3_err_count", 32'(err_count), 3);
        checkOutput("inj3_chk_count", 32'(chk_count), 24);

        // Reset mid-CHECK with en high: reset wins.
        applyStimulus(1'b1, 1'b1, 9'(val));
        checkClear("midreset");
        applyStimulus(1'b0, 1'b0, 9'd0);
        checkOutput("midreset_idle_hold", 32'(state), 0);

        // Stall during FILL at fill=2.
        val = 100;
        applyStimulus(1'b0, 1'b1, 9'(val)); val++;
        applyStimulus(1'b0, 1'b1, 9'(val)); val++;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 9'h155);
            checkOutput("stall_fill_state", 32'(state), 1);
            checkOutput("stall_fill_chk", 32'(chk_count), 0);
        end
        applyStimulus(1'b0, 1'b1, 9'(val)); val++;
        checkOutput("resume_state_3", 32'(state), 1);
        applyStimulus(1'b0, 1'b1, 9'(val)); val++;
        checkOutput("resume_state_4", 32'(state), 2);
        checkOutput("resume_chk_0", 32'(chk_count), 0);
        applyStimulus(1'b0, 1'b1, 9'(val)); val++;
        checkOutput("resume_chk_1", 32'(chk_count), 1);
        checkOutput("resume_mismatch", 32'(mismatch), 0);

        // Glitch on c during a CHECK stall: prediction held at 101.
        force_en = 1'b1; force_val = 9'h1FF;
        applyStimulus(1'b0, 1'b0, 9'h000);
        force_en = 1'b0;
        checkOutput("stall_glitch_mismatch", 32'(mismatch), 1);
        checkOutput("stall_glitch_error", 32'(error), 1);
        checkOutput("stall_glitch_err", 32'(err_count), 1);
        checkOutput("stall_glitch_chk", 32'(chk_count), 2);
        checkOutput("stall_glitch_first_exp", 32'(first_exp), capture_on ? 32'd101 : 32'h0);
        checkOutput("stall_glitch_first_got", 32'(first_got), capture_on ? 32'h1FF : 32'h0);
        applyStimulus(1'b0, 1'b0, 9'h000);
        checkOutput("stall_after_mismatch", 32'(mismatch), 0);
        checkOutput("stall_after_chk", 32'(chk_count), 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
